dq4_serializer: RTL and testbench

DQ4_SERIALIZER -- requirements
Module: dq4_serializer

---
 rtl/dq4_pkg.sv | 26 ++
 rtl/dq4_shreg.sv | 31 +++
 rtl/dq4_serializer.sv | 134 +++++++++++++
 tb/tb_dq4_serializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dq4_pkg.sv
// Shared definitions for dq4_serializer: state encoding, default word width and parity helper.
// Optional build macro: DQ4_SER_PARITY_EN adds the PAR state and the parity function.
package dq4_pkg;

  localparam int DQ4_WIDTH_DEFAULT = 4;
  localparam int DQ4_WIDTH_MAX     = 16;

`ifdef DQ4_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } dq4_state_t;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DQ4_WIDTH_MAX-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } dq4_state_t;
`endif

endpackage

// File: rtl/dq4_shreg.sv
// Parallel-load shift register for dq4_serializer; shifts toward index 0, zero-filling the tail.
// q0 is the serial output bit and is a direct flop output.
module dq4_shreg
  import dq4_pkg::*;
#(
  parameter int WIDTH = DQ4_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [0:WIDTH-1] d,
  output logic             q0
);

  logic [0:WIDTH-1] q;

  // Zero-fill matters: once a frame has shifted out, q0 rests at 0 for IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[1:WIDTH-1], 1'b0};
    end
  end

  assign q0 = q[0];

endmodule

// File: rtl/dq4_serializer.sv
// MSB-first parallel-to-serial converter with frame start marker and one idle cycle between frames.
// Optional build macro: DQ4_SER_PARITY_EN appends an even-parity bit (PAR state) to each frame.
module dq4_serializer
  import dq4_pkg::*;
#(
  parameter int WIDTH = DQ4_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] D,
  input  logic             en,
  output logic             rdy,
  output logic             sout,
  output logic             sout_vld,
  output logic             sout_sof,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  dq4_state_t       state;
  dq4_state_t       state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             capture;
  logic             vld_d;
  logic             sof_d;
  logic             sh_load;
  logic             sh_shift;
  logic [0:WIDTH-1] sh_data;
`ifdef DQ4_SER_PARITY_EN
  logic             par_q;
`endif

  assign rdy     = (state == IDLE) && rst_n;
  assign capture = en && rdy;

  dq4_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sh_load),
    .shift(sh_shift),
    .d    (sh_data),
    .q0   (sout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic also decides what the shift register does so that
  // the serial bit, valid and start-of-frame all change on the same edge.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    vld_d    = 1'b0;
    sof_d    = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = D;
    case (state)
      IDLE: begin
        if (capture) begin
          state_d = SHIFT;
          cnt_d   = '0;
          vld_d   = 1'b1;
          sof_d   = 1'b1;
          sh_load = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          cnt_d = '0;
`ifdef DQ4_SER_PARITY_EN
          state_d    = PAR;
          vld_d      = 1'b1;
          sh_load    = 1'b1;
          sh_data    = '0;
          sh_data[0] = par_q;
`else
          state_d  = IDLE;
          sh_shift = 1'b1;
`endif
        end else begin
          cnt_d    = cnt + CW'(1);
          vld_d    = 1'b1;
          sh_shift = 1'b1;
        end
      end
`ifdef DQ4_SER_PARITY_EN
      PAR: begin
        state_d  = IDLE;
        sh_shift = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sout_vld <= 1'b0;
      sout_sof <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      sout_vld <= vld_d;
      sout_sof <= sof_d;
      busy     <= (state_d != IDLE);
    end
  end

`ifdef DQ4_SER_PARITY_EN
  // The shift register is consumed while sending, so parity is frozen at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= even_parity(DQ4_WIDTH_MAX'(D));
    end
  end
`endif

endmodule

// File: tb/tb_dq4_serializer.sv
// Self-checking bench for dq4_serializer: WIDTH=4 and WIDTH=8 instances against a queue-based frame model.
// Honours DQ4_SER_PARITY_EN when the bench is built with it.
module tb_dq4_serializer;

`ifdef DQ4_SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:3] d4;
  logic       en4;
  logic       rdy4, sout4, vld4, sof4, busy4;
  logic [0:7] d8;
  logic       en8;
  logic       rdy8, sout8, vld8, sof8, busy8;

  int checks = 0;
  int errors = 0;

  // Model: each queue entry is {sof, bit} for one future valid output cycle.
  logic [1:0] q4[$];
  logic [1:0] q8[$];
  logic [1:0] cur4, cur8;
  bit         show4, show8;

  always #5 clk = ~clk;

  dq4_serializer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .D(d4), .en(en4), .rdy(rdy4),
    .sout(sout4), .sout_vld(vld4), .sout_sof(sof4), .busy(busy4)
  );

  dq4_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .D(d8), .en(en8), .rdy(rdy8),
    .sout(sout8), .sout_vld(vld8), .sout_sof(sof8), .busy(busy8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Packed view {rdy, busy, sof, vld, sout}.
  function automatic logic [4:0] expVec(input bit show, input logic [1:0] cur);
    return {(!show) && (rst_n === 1'b1), show, cur[1], show, cur[0]};
  endfunction

  task automatic checkAll();
    checkOutput("dut4_outputs", {27'd0, rdy4, busy4, sof4, vld4, sout4}, {27'd0, expVec(show4, cur4)});
    checkOutput("dut8_outputs", {27'd0, rdy8, busy8, sof8, vld8, sout8}, {27'd0, expVec(show8, cur8)});
  endtask

  task automatic modelReset();
    q4.delete();
    q8.delete();
    show4 = 1'b0;
    show8 = 1'b0;
    cur4  = 2'b00;
    cur8  = 2'b00;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic modelStep();
    if (!show4 && en4) begin
      for (int i = 0; i < 4; i++) q4.push_back({(i == 0), d4[i]});
      if (PAR_BITS != 0) q4.push_back({1'b0, (($countones(d4) % 2) == 1)});
    end
    if (!show8 && en8) begin
      for (int i = 0; i < 8; i++) q8.push_back({(i == 0), d8[i]});
      if (PAR_BITS != 0) q8.push_back({1'b0, (($countones(d8) % 2) == 1)});
    end
    if (q4.size() != 0) begin cur4 = q4.pop_front(); show4 = 1'b1; end
    else begin cur4 = 2'b00; show4 = 1'b0; end
    if (q8.size() != 0) begin cur8 = q8.pop_front(); show8 = 1'b1; end
    else begin cur8 = 2'b00; show8 = 1'b0; end
  endtask

  task automatic applyStimulus(input logic rst, input logic [0:3] dv4, input logic ev4,
                               input logic [0:7] dv8, input logic ev8);
    @(negedge clk);
    checkAll();
    rst_n = rst;
    d4    = dv4;
    en4   = ev4;
    d8    = dv8;
    en8   = ev8;
    if (!rst) begin
      modelReset();
      #1;
      checkAll();
    end else begin
      modelStep();
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] a5_bits;
  int         a5_nbits;
  int         a5_busy;

  initial begin
    rst_n = 1'b0;
    d4    = '0;
    en4   = 1'b0;
    d8    = '0;
    en8   = 1'b0;
    modelReset();

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00, 1'b0);
    idleCycles(2);

    applyStimulus(1'b1, 4'b1011, 1'b1, 8'h00, 1'b0);
    idleCycles(7);

    applyStimulus(1'b1, 4'b0110, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);

    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 4'b1111, 1'b1, 8'h00, 1'b0);
    idleCycles(6);

    applyStimulus(1'b1, 4'b1010, 1'b1, 8'h00, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00, 1'b0);
    idleCycles(3);

    applyStimulus(1'b1, 4'b0111, 1'b1, 8'h00, 1'b0);
    idleCycles(7);
    applyStimulus(1'b1, 4'b0101, 1'b1, 8'h00, 1'b0);
    idleCycles(7);

    applyStimulus(1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1);
    a5_bits  = 8'h00;
    a5_nbits = 0;
    a5_busy  = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);
      if (vld8 && a5_nbits < 8) begin
        a5_bits = {a5_bits[6:0], sout8};
        a5_nbits++;
      end
      if (busy8) a5_busy++;
    end
    checkOutput("a5_serial_bits", {24'd0, a5_bits}, 32'h0000_00A5);
    checkOutput("a5_busy_cycles", a5_busy, 8 + PAR_BITS);

    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    4'($urandom), ($urandom_range(0, 3) != 0),
                    8'($urandom), ($urandom_range(0, 2) != 0));
    end
    idleCycles(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
